button_conditioner_array: RTL and testbench

BUTTON_CONDITIONER_ARRAY -- requirements
Module: button_conditioner_array

---
 rtl/button_conditioner_array.sv | 92 +++++++++
 tb/tb_button_conditioner_array.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner_array.sv
// Per-channel button conditioning: polarity fix, two-flop synchronizer, debounce,
// press/release strobes and long-press detection, plus a registered any-pressed flag.
module button_conditioner_array #(
   parameter int                  CHANNELS          = 4,
   parameter int                  DEBOUNCE_CYCLES   = 1_500_000,
   parameter int                  LONG_PRESS_CYCLES = 50_000_000,
   parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK   = '0
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic [CHANNELS-1:0] buttonPress,
   output logic [CHANNELS-1:0] conditionedSignal,
   output logic [CHANNELS-1:0] pressPulse,
   output logic [CHANNELS-1:0] releasePulse,
   output logic [CHANNELS-1:0] longPressPulse,
   output logic [CHANNELS-1:0] heldLong,
   output logic                anyPressed
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_PRESS_CYCLES - 1);
   localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_PRESS_CYCLES);

   logic [CHANNELS-1:0] syncA;
   logic [CHANNELS-1:0] syncB;
   logic [DW-1:0]       debCnt [CHANNELS];
   logic [LW-1:0]       holdCnt [CHANNELS];
   logic [CHANNELS-1:0] accept;
   logic [CHANNELS-1:0] releasing;
   logic [CHANNELS-1:0] longHit;

   // accept fires on the edge where the debounce count would reach its target
   always_comb begin
      accept    = '0;
      releasing = '0;
      longHit   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         accept[i]    = (syncB[i] != conditionedSignal[i]) && (debCnt[i] == DEB_LAST);
         releasing[i] = accept[i] && !syncB[i];
         longHit[i]   = conditionedSignal[i] && (holdCnt[i] == HOLD_LAST) && !releasing[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         syncA             <= '0;
         syncB             <= '0;
         conditionedSignal <= '0;
         pressPulse        <= '0;
         releasePulse      <= '0;
         longPressPulse    <= '0;
         heldLong          <= '0;
         anyPressed        <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            debCnt[i]  <= '0;
            holdCnt[i] <= '0;
         end
      end else begin
         syncA          <= buttonPress ^ ACTIVE_LOW_MASK;
         syncB          <= syncA;
         anyPressed     <= |conditionedSignal;
         pressPulse     <= accept & syncB;
         releasePulse   <= accept & ~syncB;
         longPressPulse <= longHit;
         for (int i = 0; i < CHANNELS; i++) begin
            // any agreement between sync and the accepted level restarts the count
            if ((syncB[i] == conditionedSignal[i]) || accept[i]) begin
               debCnt[i] <= '0;
            end else begin
               debCnt[i] <= debCnt[i] + 1'b1;
            end
            if (accept[i]) begin
               conditionedSignal[i] <= syncB[i];
            end
            if (!conditionedSignal[i]) begin
               holdCnt[i] <= '0;
            end else if (holdCnt[i] != HOLD_MAX) begin
               holdCnt[i] <= holdCnt[i] + 1'b1;
            end
            // a release landing on the long-press edge wins, so heldLong never outlives it
            if (releasing[i]) begin
               heldLong[i] <= 1'b0;
            end else if (longHit[i]) begin
               heldLong[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_button_conditioner_array.sv
// Bench for button_conditioner_array: expected output snapshots are queued per cycle
// from a closed-form timing model and compared at the falling edge.
module tb_button_conditioner_array;

   typedef struct packed {
      logic [3:0] cond;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] longP;
      logic [3:0] held;
      logic       any;
   } outs_t;

   typedef struct {
      int    atCycle;
      string name;
      outs_t exp;
   } sb_t;

   typedef struct {
      string      name;
      logic [3:0] ch;
      int         hold;
   } vec_t;

   logic       clk = 1'b0;
   logic       resetN;
   logic [3:0] pins;
   logic [3:0] conditionedSignal;
   logic [3:0] pressPulse;
   logic [3:0] releasePulse;
   logic [3:0] longPressPulse;
   logic [3:0] heldLong;
   logic       anyPressed;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   sb_t sbQ[$];

   button_conditioner_array #(
      .CHANNELS(4),
      .DEBOUNCE_CYCLES(4),
      .LONG_PRESS_CYCLES(10),
      .ACTIVE_LOW_MASK(4'b1000)
   ) dut (
      .clk(clk),
      .resetN(resetN),
      .buttonPress(pins),
      .conditionedSignal(conditionedSignal),
      .pressPulse(pressPulse),
      .releasePulse(releasePulse),
      .longPressPulse(longPressPulse),
      .heldLong(heldLong),
      .anyPressed(anyPressed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Outputs for a press of logical channels ch, driven just after edge m and released
   // just after edge m+h, observed after edge c (idle state before m assumed).
   function automatic outs_t model(int m, int h, logic [3:0] ch, int c);
      outs_t o;
      int    r;
      logic  cd, pr, rl, lp, hl, an;
      o  = '0;
      r  = c - m;
      cd = 1'b0; pr = 1'b0; rl = 1'b0; lp = 1'b0; hl = 1'b0; an = 1'b0;
      if (h >= 4) begin
         cd = (r >= 6) && (r <= h + 5);
         pr = (r == 6);
         rl = (r == h + 6);
         an = (r >= 7) && (r <= h + 6);
         if (h > 10) begin
            lp = (r == 16);
            hl = (r >= 16) && (r <= h + 5);
         end
      end
      o.cond  = cd ? ch : 4'b0;
      o.press = pr ? ch : 4'b0;
      o.rel   = rl ? ch : 4'b0;
      o.longP = lp ? ch : 4'b0;
      o.held  = hl ? ch : 4'b0;
      o.any   = an && (ch != 4'b0);
      return o;
   endfunction

   task automatic pushRange(input string name, input int m, input int h,
                            input logic [3:0] ch, input int fromC, input int toC);
      sb_t e;
      for (int c = fromC; c <= toC; c++) begin
         e.atCycle = c;
         e.name    = name;
         e.exp     = model(m, h, ch, c);
         sbQ.push_back(e);
      end
   endtask

   task automatic pushZeros(input string name, input int fromC, input int toC);
      pushRange(name, 0, 0, 4'b0, fromC, toC);
   endtask

   // pressedCh is the logical press pattern; ch3 is wired active-low
   task automatic applyStimulus(input logic [3:0] pressedCh, input logic rst);
      pins   = 4'b1000 ^ pressedCh;
      resetN = rst;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      outs_t act;
      int    idx;
      act.cond  = conditionedSignal;
      act.press = pressPulse;
      act.rel   = releasePulse;
      act.longP = longPressPulse;
      act.held  = heldLong;
      act.any   = anyPressed;
      idx = 0;
      while (idx < sbQ.size()) begin
         if (sbQ[idx].atCycle <= cyc) begin
            if (sbQ[idx].atCycle < cyc) begin
               checks++;
               errors++;
               $display("[TB] FAIL %s stale entry for cyc=%0d at cyc=%0d",
                        sbQ[idx].name, sbQ[idx].atCycle, cyc);
            end else begin
               checkOutput(sbQ[idx].name, act, sbQ[idx].exp);
            end
            sbQ.delete(idx);
         end else begin
            idx++;
         end
      end
   end

   vec_t vecs[8];

   initial begin
      int m;
      vecs[0] = '{"ch0_clean",    4'b0001, 8};
      vecs[1] = '{"ch1_clean",    4'b0010, 6};
      vecs[2] = '{"ch2_long",     4'b0100, 20};
      vecs[3] = '{"ch3_actlow",   4'b1000, 8};
      vecs[4] = '{"simul01",      4'b0011, 12};
      vecs[5] = '{"all_long11",   4'b1111, 11};
      vecs[6] = '{"ch1_min_hold", 4'b0010, 4};
      vecs[7] = '{"ch0_too_short",4'b0001, 3};

      resetN = 1'b0;
      pins   = 4'b0110;
      pushZeros("reset", 1, 4);
      tick(4);
      applyStimulus(4'b0000, 1'b1);
      pushZeros("idle", cyc + 1, cyc + 8);
      tick(8);

      foreach (vecs[i]) begin
         m = cyc;
         applyStimulus(vecs[i].ch, 1'b1);
         pushRange(vecs[i].name, m, vecs[i].hold, vecs[i].ch, m + 1, m + vecs[i].hold + 8);
         tick(vecs[i].hold);
         applyStimulus(4'b0000, 1'b1);
         tick(8);
      end

      // ch1 bounce: high 3, low 1, high 3, then low
      m = cyc;
      applyStimulus(4'b0010, 1'b1);
      pushZeros("bounce", m + 1, m + 16);
      tick(3);
      applyStimulus(4'b0000, 1'b1);
      tick(1);
      applyStimulus(4'b0010, 1'b1);
      tick(3);
      applyStimulus(4'b0000, 1'b1);
      tick(9);

      // reset on the second debounce count, pin kept pressed through it
      m = cyc;
      applyStimulus(4'b0001, 1'b1);
      pushZeros("rstMidDeb", m + 1, m + 4);
      tick(3);
      applyStimulus(4'b0001, 1'b0);
      tick(1);
      applyStimulus(4'b0001, 1'b1);
      pushRange("rstMidDebAfter", m + 4, 8, 4'b0001, m + 5, m + 20);
      tick(8);
      applyStimulus(4'b0000, 1'b1);
      tick(8);

      // reset while a long press is counting: no long, no release strobe
      m = cyc;
      applyStimulus(4'b0100, 1'b1);
      pushRange("rstLong", m, 20, 4'b0100, m + 1, m + 13);
      tick(13);
      applyStimulus(4'b0000, 1'b0);
      tick(1);
      applyStimulus(4'b0000, 1'b1);
      pushZeros("rstLongAfter", m + 14, m + 34);
      tick(22);

      if (sbQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL leftover actual=%0d pending required=0", sbQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
